dac_pulse_sequencer: RTL

- Upstream command generator for the AD5725 DAC interface.
- Turns one host pulse request (channel, pulse level, baseline level, width, gap, repeat count) into a train of DAC write commands on the DAC command bus (cs/op/addr/data_in/rdy).
- Handles pulse/gap timing and the DAC ready handshake, so memristor voltage pulses are cycle-timed in fabric rather than by the host.

---
 rtl/dac_pulse_sequencer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dac_pulse_sequencer.sv
// Pulse-train command generator for the AD5725 DAC command bus: alternates pulse and
// baseline writes with cycle-exact hold/gap timing and honours the DAC ready handshake.
module dac_pulse_sequencer #(
    parameter int BLANK  = 3,
    parameter int W_TIME = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        channel,
    input  logic [11:0]       v_pulse,
    input  logic [11:0]       v_base,
    input  logic [W_TIME-1:0] width,
    input  logic [W_TIME-1:0] gap,
    input  logic [7:0]        count,
    output logic              busy,
    output logic              done,
    output logic [7:0]        pulses_left,
    output logic              dac_cs,
    output logic [3:0]        dac_op,
    output logic [7:0]        dac_addr,
    output logic [15:0]       dac_data,
    input  logic              dac_rdy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_BLANKW  = 3'd2,
        S_WAITRDY = 3'd3,
        S_HOLD    = 3'd4,
        S_GAP     = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        WR_INIT  = 2'd0,
        WR_PULSE = 2'd1,
        WR_BASE  = 2'd2
    } wr_kind_t;

    localparam logic [3:0]        OP_WRITE  = 4'b0010;
    localparam logic [3:0]        OP_RESET  = 4'b0001;
    localparam logic [W_TIME-1:0] T_ZERO    = {W_TIME{1'b0}};
    localparam logic [W_TIME-1:0] T_ONE     = {{(W_TIME-1){1'b0}}, 1'b1};
    localparam logic [W_TIME-1:0] BLANK_CYC = W_TIME'(BLANK);

    state_t            state_r, state_nx;
    wr_kind_t          kind_r, kind_nx;
    logic [7:0]        pl_r, pl_nx;
    logic [W_TIME-1:0] tcnt_r, tcnt_nx;
    logic              pend_r, pend_nx;
    logic [1:0]        ch_r;
    logic [11:0]       vp_r, vb_r;
    logic [W_TIME-1:0] width_r, gap_r;
    logic [W_TIME-1:0] hold_tgt_s, gap_tgt_s;
    logic              accept_start_s, from_idle_s;
    logic [3:0]        cmd_op_s;
    logic [7:0]        cmd_addr_s;
    logic [15:0]       cmd_data_s;
    logic              done_r, cs_r;
    logic [3:0]        op_r;
    logic [7:0]        addr_r;
    logic [15:0]       data_r;

    // Zero width/gap still yields a single cycle, so the time counters never need to wrap.
    assign hold_tgt_s     = (width_r == T_ZERO) ? T_ONE : width_r;
    assign gap_tgt_s      = (gap_r == T_ZERO) ? T_ONE : gap_r;
    assign accept_start_s = (state_r == S_IDLE) & ~init & start;
    assign from_idle_s    = (state_r == S_IDLE);

    // Next-state, pulse bookkeeping and abort recording.
    always_comb begin
        state_nx = state_r;
        kind_nx  = kind_r;
        pl_nx    = pl_r;
        tcnt_nx  = tcnt_r;
        pend_nx  = pend_r;
        case (state_r)
            S_IDLE: begin
                pend_nx = 1'b0;
                if (init) begin
                    kind_nx  = WR_INIT;
                    state_nx = S_ISSUE;
                end else if (start) begin
                    pl_nx = count;
                    if (count == 8'd0) begin
                        state_nx = S_FINISH;
                    end else begin
                        kind_nx  = WR_PULSE;
                        state_nx = S_ISSUE;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_ISSUE, S_BLANKW: begin
                if (abort) begin
                    pend_nx = 1'b1;
                    pl_nx   = 8'd0;
                end else begin
                    pend_nx = pend_r;
                end
                if (state_r == S_ISSUE) begin
                    tcnt_nx  = T_ONE;
                    state_nx = S_BLANKW;
                end else if (tcnt_r == BLANK_CYC) begin
                    state_nx = S_WAITRDY;
                end else begin
                    tcnt_nx = tcnt_r + T_ONE;
                end
            end
            S_WAITRDY: begin
                if (abort) begin
                    pend_nx = 1'b1;
                    pl_nx   = 8'd0;
                end else begin
                    pend_nx = pend_r;
                end
                if (dac_rdy) begin
                    case (kind_r)
                        WR_PULSE: begin
                            if (pend_r | abort) begin
                                kind_nx  = WR_BASE;
                                state_nx = S_ISSUE;
                            end else begin
                                tcnt_nx  = T_ONE;
                                state_nx = S_HOLD;
                            end
                        end
                        WR_BASE: begin
                            if (pend_r | abort | (pl_r == 8'd0)) begin
                                state_nx = S_FINISH;
                            end else begin
                                tcnt_nx  = T_ONE;
                                state_nx = S_GAP;
                            end
                        end
                        default: state_nx = S_FINISH;
                    endcase
                end else begin
                    state_nx = S_WAITRDY;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    pl_nx    = 8'd0;
                    kind_nx  = WR_BASE;
                    state_nx = S_ISSUE;
                end else if (tcnt_r == hold_tgt_s) begin
                    pl_nx    = pl_r - 8'd1;
                    kind_nx  = WR_BASE;
                    state_nx = S_ISSUE;
                end else begin
                    tcnt_nx = tcnt_r + T_ONE;
                end
            end
            S_GAP: begin
                if (abort | (pl_r == 8'd0)) begin
                    state_nx = S_FINISH;
                end else if (tcnt_r == gap_tgt_s) begin
                    kind_nx  = WR_PULSE;
                    state_nx = S_ISSUE;
                end else begin
                    tcnt_nx = tcnt_r + T_ONE;
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Command fields for the next strobe; a train's first write uses the live inputs.
    always_comb begin
        case (kind_nx)
            WR_INIT: begin
                cmd_op_s   = OP_RESET;
                cmd_addr_s = 8'h00;
                cmd_data_s = 16'h0000;
            end
            WR_PULSE: begin
                cmd_op_s   = OP_WRITE;
                cmd_addr_s = {6'b000000, from_idle_s ? channel : ch_r};
                cmd_data_s = {4'b0000, from_idle_s ? v_pulse : vp_r};
            end
            WR_BASE: begin
                cmd_op_s   = OP_WRITE;
                cmd_addr_s = {6'b000000, ch_r};
                cmd_data_s = {4'b0000, vb_r};
            end
            default: begin
                cmd_op_s   = 4'b0000;
                cmd_addr_s = 8'h00;
                cmd_data_s = 16'h0000;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            kind_r  <= WR_INIT;
            pl_r    <= 8'd0;
            tcnt_r  <= T_ZERO;
            pend_r  <= 1'b0;
            done_r  <= 1'b0;
            cs_r    <= 1'b0;
            op_r    <= 4'b0000;
            addr_r  <= 8'h00;
            data_r  <= 16'h0000;
        end else begin
            state_r <= state_nx;
            kind_r  <= kind_nx;
            pl_r    <= pl_nx;
            tcnt_r  <= tcnt_nx;
            pend_r  <= pend_nx;
            done_r  <= (state_nx == S_FINISH);
            cs_r    <= (state_nx == S_ISSUE);
            if (state_nx == S_ISSUE) begin
                op_r   <= cmd_op_s;
                addr_r <= cmd_addr_s;
                data_r <= cmd_data_s;
            end
        end
    end

    // Train parameters captured when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_r    <= 2'd0;
            vp_r    <= 12'h000;
            vb_r    <= 12'h000;
            width_r <= T_ZERO;
            gap_r   <= T_ZERO;
        end else if (accept_start_s) begin
            ch_r    <= channel;
            vp_r    <= v_pulse;
            vb_r    <= v_base;
            width_r <= width;
            gap_r   <= gap;
        end
    end

    assign busy        = (state_r != S_IDLE) | init | start;
    assign done        = done_r;
    assign pulses_left = pl_r;
    assign dac_cs      = cs_r;
    assign dac_op      = op_r;
    assign dac_addr    = addr_r;
    assign dac_data    = data_r;

endmodule
